// File: rtl/ether_hdr_prepend.sv
// Header-prepend stage for the TX path.
// Consumes one header word per frame and a framed byte stream (sop/eop/mty),
// and emits the header followed by the payload shifted down by HDR_BYTES.
// All three interfaces use valid/ready. The output is a single register stage.
module ether_hdr_prepend #(
    parameter int DATA_W    = 512,
    parameter int HDR_BYTES = 14,
    parameter int MTY_W     = 8,
    parameter int CNT_W     = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [HDR_BYTES*8-1:0] ether_header_data,
    input  logic                   ether_header_valid,
    output logic                   ether_header_ready,
    input  logic [DATA_W-1:0]      ether_data_data,
    input  logic                   ether_data_valid,
    output logic                   ether_data_ready,
    input  logic                   ether_data_sop,
    input  logic                   ether_data_eop,
    input  logic [MTY_W-1:0]       ether_data_mty,
    output logic [DATA_W-1:0]      send_data,
    output logic                   send_valid,
    input  logic                   send_ready,
    output logic                   send_sop,
    output logic                   send_eop,
    output logic [MTY_W-1:0]       send_mty,
    output logic                   orphan_err,
    output logic [CNT_W-1:0]       frame_cnt
);

    localparam int BYTES = DATA_W / 8;
    localparam int H     = HDR_BYTES * 8;

    // Largest meaningful mty, the header length, and the tail length that
    // spills into the extra LAST beat, all expressed in mty units.
    localparam logic [MTY_W-1:0] MAX_MTY  = MTY_W'(BYTES - 1);
    localparam logic [MTY_W-1:0] HDR_MTY  = MTY_W'(HDR_BYTES);
    localparam logic [MTY_W-1:0] TAIL_MTY = MTY_W'(BYTES - HDR_BYTES);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        LAST
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  send_data_q, send_data_d;
    logic               send_valid_q, send_valid_d;
    logic               send_sop_q, send_sop_d;
    logic               send_eop_q, send_eop_d;
    logic [MTY_W-1:0]   send_mty_q, send_mty_d;
    logic [H-1:0]       carry_q, carry_d;
    logic [MTY_W-1:0]   mty_reg_q, mty_reg_d;
    logic               orphan_q, orphan_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;

    logic               adv;
    logic               take_beat;
    logic [MTY_W-1:0]   m_clip;

    // Next-state, datapath and handshake decode.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d            = state_q;
        send_data_d        = send_data_q;
        send_valid_d       = send_valid_q;
        send_sop_d         = send_sop_q;
        send_eop_d         = send_eop_q;
        send_mty_d         = send_mty_q;
        carry_d            = carry_q;
        mty_reg_d          = mty_reg_q;
        orphan_d           = 1'b0;
        frame_cnt_d        = frame_cnt_q;
        ether_data_ready   = 1'b0;
        ether_header_ready = 1'b0;
        take_beat          = 1'b0;

        adv    = !send_valid_q || send_ready;
        m_clip = (ether_data_mty > MAX_MTY) ? MAX_MTY : ether_data_mty;

        if (send_valid_q && send_ready && send_eop_q) begin
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
        end

        // When the output register may advance and nothing new is produced,
        // the output slot empties.
        if (adv) begin
            send_valid_d = 1'b0;
            send_sop_d   = 1'b0;
            send_eop_d   = 1'b0;
            send_mty_d   = '0;
        end

        case (state_q)
            IDLE: begin
                // A sop beat is held off until its header is present.
                ether_data_ready   = adv && !(ether_data_sop && !ether_header_valid);
                ether_header_ready = adv && ether_data_valid && ether_data_sop && ether_header_valid;
                if (ether_data_valid && ether_data_ready) begin
                    if (ether_data_sop) begin
                        send_data_d  = {ether_header_data, ether_data_data[DATA_W-1:H]};
                        send_valid_d = 1'b1;
                        send_sop_d   = 1'b1;
                        carry_d      = ether_data_data[H-1:0];
                        state_d      = RECV;
                        take_beat    = 1'b1;
                    end else begin
                        orphan_d = 1'b1;
                    end
                end
            end
            RECV: begin
                ether_data_ready = adv;
                if (ether_data_valid && adv) begin
                    send_data_d  = {carry_q, ether_data_data[DATA_W-1:H]};
                    send_valid_d = 1'b1;
                    carry_d      = ether_data_data[H-1:0];
                    take_beat    = 1'b1;
                end
            end
            LAST: begin
                if (adv) begin
                    send_data_d  = {carry_q, {(DATA_W-H){1'b0}}};
                    send_valid_d = 1'b1;
                    send_eop_d   = 1'b1;
                    send_mty_d   = mty_reg_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // The end of the input frame either fits in this beat or spills the
        // carried bytes into one extra LAST beat.
        if (take_beat && ether_data_eop) begin
            if (m_clip >= HDR_MTY) begin
                send_eop_d = 1'b1;
                send_mty_d = m_clip - HDR_MTY;
                state_d    = IDLE;
            end else begin
                mty_reg_d = m_clip + TAIL_MTY;
                state_d   = LAST;
            end
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            send_data_q  <= '0;
            send_valid_q <= 1'b0;
            send_sop_q   <= 1'b0;
            send_eop_q   <= 1'b0;
            send_mty_q   <= '0;
            carry_q      <= '0;
            mty_reg_q    <= '0;
            orphan_q     <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q      <= state_d;
            send_data_q  <= send_data_d;
            send_valid_q <= send_valid_d;
            send_sop_q   <= send_sop_d;
            send_eop_q   <= send_eop_d;
            send_mty_q   <= send_mty_d;
            carry_q      <= carry_d;
            mty_reg_q    <= mty_reg_d;
            orphan_q     <= orphan_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign send_data  = send_data_q;
    assign send_valid = send_valid_q;
    assign send_sop   = send_sop_q;
    assign send_eop   = send_eop_q;
    assign send_mty   = send_mty_q;
    assign orphan_err = orphan_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_ether_hdr_prepend.sv
// Directed bench for ether_hdr_prepend: a default 512/14 instance and a
// 256/18 instance. Expected beats are built from byte sequences by mk().
module tb_ether_hdr_prepend;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // Default instance (DATA_W=512, HDR_BYTES=14)
    logic [111:0] hdr;
    logic         hdr_valid, hdr_ready;
    logic [511:0] d_data;
    logic         d_valid, d_ready, d_sop, d_eop;
    logic [7:0]   d_mty;
    logic [511:0] s_data;
    logic         s_valid, s_ready, s_sop, s_eop;
    logic [7:0]   s_mty;
    logic         orphan;
    logic [31:0]  fcnt;

    // Narrow instance (DATA_W=256, HDR_BYTES=18)
    logic [143:0] b_hdr;
    logic         b_hdr_valid, b_hdr_ready;
    logic [255:0] b_d_data;
    logic         b_d_valid, b_d_ready, b_d_sop, b_d_eop;
    logic [7:0]   b_d_mty;
    logic [255:0] b_s_data;
    logic         b_s_valid, b_s_ready, b_s_sop, b_s_eop;
    logic [7:0]   b_s_mty;
    logic         b_orphan;
    logic [31:0]  b_fcnt;

    ether_hdr_prepend u_dut (
        .clk(clk), .reset(reset),
        .ether_header_data(hdr), .ether_header_valid(hdr_valid), .ether_header_ready(hdr_ready),
        .ether_data_data(d_data), .ether_data_valid(d_valid), .ether_data_ready(d_ready),
        .ether_data_sop(d_sop), .ether_data_eop(d_eop), .ether_data_mty(d_mty),
        .send_data(s_data), .send_valid(s_valid), .send_ready(s_ready),
        .send_sop(s_sop), .send_eop(s_eop), .send_mty(s_mty),
        .orphan_err(orphan), .frame_cnt(fcnt)
    );

    ether_hdr_prepend #(.DATA_W(256), .HDR_BYTES(18), .MTY_W(8), .CNT_W(32)) u_dut_b (
        .clk(clk), .reset(reset),
        .ether_header_data(b_hdr), .ether_header_valid(b_hdr_valid), .ether_header_ready(b_hdr_ready),
        .ether_data_data(b_d_data), .ether_data_valid(b_d_valid), .ether_data_ready(b_d_ready),
        .ether_data_sop(b_d_sop), .ether_data_eop(b_d_eop), .ether_data_mty(b_d_mty),
        .send_data(b_s_data), .send_valid(b_s_valid), .send_ready(b_s_ready),
        .send_sop(b_s_sop), .send_eop(b_s_eop), .send_mty(b_s_mty),
        .orphan_err(b_orphan), .frame_cnt(b_fcnt)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        hdr_valid = 1'b0;
        d_valid   = 1'b0;
        d_sop     = 1'b0;
        d_eop     = 1'b0;
        d_mty     = '0;
    endtask

    // nbytes-wide value (LSB aligned): n0 bytes counting up from b0, then
    // n1 bytes counting up from b1, then zero bytes. Byte 0 is the MSB byte.
    function automatic logic [511:0] mk(input int nbytes, input int b0, input int n0,
                                        input int b1, input int n1);
        logic [511:0] v;
        int           val;
        v = '0;
        for (int k = 0; k < nbytes; k++) begin
            if (k < n0)           val = b0 + k;
            else if (k < n0 + n1) val = b1 + k - n0;
            else                  val = 0;
            v[(nbytes-1-k)*8 +: 8] = 8'(val);
        end
        return v;
    endfunction

    // Watchdog: the directed sequence is short; this only guards against a hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] tmp;
        logic [511:0] in3 [3];
        logic [511:0] exp3 [4];
        logic [511:0] held;
        logic         held_eop, held_sop, stalled;
        logic [7:0]   held_mty;
        int           in_idx, out_idx;

        reset = 1'b1;
        tmp = mk(14, 1, 14, 0, 0);
        hdr = tmp[111:0];
        d_data = '0;
        idle_a();
        s_ready = 1'b1;
        b_hdr = '0; b_hdr_valid = 1'b0; b_d_data = '0; b_d_valid = 1'b0;
        b_d_sop = 1'b0; b_d_eop = 1'b0; b_d_mty = '0; b_s_ready = 1'b1;

        // ---- Reset state ----
        tick();
        tick();
        check("rst_valid", s_valid, 0);
        check("rst_data", s_data, 0);
        check("rst_mty", s_mty, 0);
        check("rst_fcnt", fcnt, 0);
        check("rst_orphan", orphan, 0);
        #2 reset = 1'b0;
        tick();

        // ---- T1: single beat, mty=20, fits in one output beat ----
        hdr_valid = 1'b1; d_valid = 1'b1; d_sop = 1'b1; d_eop = 1'b1; d_mty = 8'd20;
        d_data = mk(64, 'h10, 64, 0, 0);
        #1;
        check("t1_hdr_ready", hdr_ready, 1);
        check("t1_data_ready", d_ready, 1);
        tick();
        idle_a();
        #1;
        check("t1_hdr_ready_drop", hdr_ready, 0);
        check("t1_valid", s_valid, 1);
        check("t1_sop", s_sop, 1);
        check("t1_eop", s_eop, 1);
        check("t1_mty", s_mty, 6);
        check("t1_data", s_data, mk(64, 1, 14, 'h10, 50));
        tick();
        check("t1_valid_drop", s_valid, 0);
        check("t1_fcnt", fcnt, 1);

        // ---- T2: single beat, mty=4, spills into a LAST beat ----
        hdr_valid = 1'b1; d_valid = 1'b1; d_sop = 1'b1; d_eop = 1'b1; d_mty = 8'd4;
        d_data = mk(64, 'h80, 64, 0, 0);
        tick();
        idle_a();
        #1;
        check("t2_o1_sop", s_sop, 1);
        check("t2_o1_eop", s_eop, 0);
        check("t2_o1_mty", s_mty, 0);
        check("t2_o1_data", s_data, mk(64, 1, 14, 'h80, 50));
        check("t2_ready_last", d_ready, 0);
        tick();
        check("t2_o2_valid", s_valid, 1);
        check("t2_o2_sop", s_sop, 0);
        check("t2_o2_eop", s_eop, 1);
        check("t2_o2_mty", s_mty, 54);
        check("t2_o2_data", s_data, mk(64, 'h80 + 50, 14, 0, 0));
        tick();
        check("t2_valid_drop", s_valid, 0);
        check("t2_fcnt", fcnt, 2);

        // ---- T3: three-beat frame, mty=0, send_ready toggling 1010... ----
        in3[0] = mk(64, 'h20, 64, 0, 0);
        in3[1] = mk(64, 'h60, 64, 0, 0);
        in3[2] = mk(64, 'hA0, 64, 0, 0);
        exp3[0] = mk(64, 1, 14, 'h20, 50);
        exp3[1] = mk(64, 'h20 + 50, 14, 'h60, 50);
        exp3[2] = mk(64, 'h60 + 50, 14, 'hA0, 50);
        exp3[3] = mk(64, 'hA0 + 50, 14, 0, 0);
        in_idx = 0; out_idx = 0; stalled = 1'b0;
        held = '0; held_eop = 1'b0; held_sop = 1'b0; held_mty = '0;
        for (int cyc = 0; cyc < 40 && out_idx < 4; cyc++) begin
            s_ready = (cyc % 2 == 0);
            if (in_idx < 3) begin
                d_valid = 1'b1; d_data = in3[in_idx];
                d_sop = (in_idx == 0); d_eop = (in_idx == 2); d_mty = '0;
                hdr_valid = (in_idx == 0);
            end else begin
                idle_a();
            end
            #1;
            if (stalled) begin
                check("t3_hold_valid", s_valid, 1);
                check("t3_hold_data", s_data, held);
                check("t3_hold_sop", s_sop, held_sop);
                check("t3_hold_eop", s_eop, held_eop);
                check("t3_hold_mty", s_mty, held_mty);
            end
            if (s_valid && out_idx == 2) check("t3_ready_in_last", d_ready, 0);
            if (s_valid && s_ready) begin
                check($sformatf("t3_o%0d_data", out_idx), s_data, exp3[out_idx]);
                check($sformatf("t3_o%0d_sop", out_idx), s_sop, (out_idx == 0));
                check($sformatf("t3_o%0d_eop", out_idx), s_eop, (out_idx == 3));
                check($sformatf("t3_o%0d_mty", out_idx), s_mty, (out_idx == 3) ? 50 : 0);
                out_idx++;
            end
            if (d_valid && d_ready) in_idx++;
            stalled  = s_valid && !s_ready;
            held     = s_data;
            held_sop = s_sop;
            held_eop = s_eop;
            held_mty = s_mty;
            @(posedge clk);
            #1;
        end
        check("t3_out_count", out_idx, 4);
        check("t3_in_count", in_idx, 3);
        s_ready = 1'b1;
        idle_a();
        tick();
        check("t3_no_extra", s_valid, 0);
        check("t3_fcnt", fcnt, 3);

        // ---- T4: orphan beat, then sop waiting for its header ----
        d_valid = 1'b1; d_sop = 1'b0; d_eop = 1'b0; d_data = mk(64, 'h55, 64, 0, 0);
        #1;
        check("t4_orphan_ready", d_ready, 1);
        tick();
        idle_a();
        #1;
        check("t4_orphan_pulse", orphan, 1);
        check("t4_orphan_no_out", s_valid, 0);
        tick();
        check("t4_orphan_clear", orphan, 0);
        check("t4_orphan_still_no_out", s_valid, 0);

        d_valid = 1'b1; d_sop = 1'b1; d_eop = 1'b1; d_mty = 8'd20;
        d_data = mk(64, 'h30, 64, 0, 0);
        #1;
        check("t4_nohdr_ready", d_ready, 0);
        check("t4_nohdr_hdr_ready", hdr_ready, 0);
        tick();
        check("t4_nohdr_ready_wait", d_ready, 0);
        check("t4_nohdr_no_out", s_valid, 0);
        hdr_valid = 1'b1;
        #1;
        check("t4_hdr_ready", hdr_ready, 1);
        check("t4_data_ready", d_ready, 1);
        tick();
        idle_a();
        #1;
        check("t4_sop", s_sop, 1);
        check("t4_eop", s_eop, 1);
        check("t4_mty", s_mty, 6);
        check("t4_data", s_data, mk(64, 1, 14, 'h30, 50));
        tick();
        check("t4_fcnt", fcnt, 4);

        // ---- T5: reset in the middle of a frame ----
        hdr_valid = 1'b1; d_valid = 1'b1; d_sop = 1'b1; d_eop = 1'b0;
        d_data = mk(64, 'h70, 64, 0, 0);
        tick();
        idle_a();
        #1;
        check("t5_pre_valid", s_valid, 1);
        check("t5_pre_sop", s_sop, 1);
        #1 reset = 1'b1;
        #1;
        check("t5_rst_valid", s_valid, 0);
        check("t5_rst_data", s_data, 0);
        check("t5_rst_sop", s_sop, 0);
        check("t5_rst_fcnt", fcnt, 0);
        #2 reset = 1'b0;
        tick();
        check("t5_idle_after_rst", s_valid, 0);
        hdr_valid = 1'b1; d_valid = 1'b1; d_sop = 1'b1; d_eop = 1'b1; d_mty = 8'd20;
        d_data = mk(64, 'h90, 64, 0, 0);
        tick();
        idle_a();
        #1;
        check("t5_sop", s_sop, 1);
        check("t5_eop", s_eop, 1);
        check("t5_mty", s_mty, 6);
        check("t5_data", s_data, mk(64, 1, 14, 'h90, 50));
        tick();
        check("t5_fcnt", fcnt, 1);

        // ---- T6: DATA_W=256, HDR_BYTES=18, single beat mty=10 ----
        tmp = mk(18, 'hC0, 18, 0, 0);
        b_hdr = tmp[143:0];
        tmp = mk(32, 'h40, 32, 0, 0);
        b_d_data = tmp[255:0];
        b_hdr_valid = 1'b1; b_d_valid = 1'b1; b_d_sop = 1'b1; b_d_eop = 1'b1; b_d_mty = 8'd10;
        #1;
        check("t6_hdr_ready", b_hdr_ready, 1);
        tick();
        b_hdr_valid = 1'b0; b_d_valid = 1'b0; b_d_sop = 1'b0; b_d_eop = 1'b0; b_d_mty = '0;
        #1;
        check("t6_o1_valid", b_s_valid, 1);
        check("t6_o1_sop", b_s_sop, 1);
        check("t6_o1_eop", b_s_eop, 0);
        check("t6_o1_data", b_s_data, mk(32, 'hC0, 18, 'h40, 14));
        tick();
        check("t6_o2_eop", b_s_eop, 1);
        check("t6_o2_mty", b_s_mty, 24);
        check("t6_o2_data", b_s_data, mk(32, 'h40 + 14, 18, 0, 0));
        tick();
        check("t6_valid_drop", b_s_valid, 0);
        check("t6_fcnt", b_fcnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
